pipeline_hazard_sequencer: RTL and testbench
============================================

// Module: pipeline_hazard_sequencer
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. It sits beside the ID-stage control decoder.
//  - Detects load-use hazards and inserts one bubble by forcing the ID/EX control word to zero.
//  - Flushes IF/ID on taken beq and on j, and selects the PC source.
//  - Freezes the pipeline while the data memory has not acknowledged a MEM-stage access.
//  - Holds the core idle until start_i, latches a memory-timeout error, and keeps stall/flush counters.
// PARAMETERS
//  CNT_W        16  width of the saturating performance counters
//  MEM_TIMEOUT  15  number of wait cycles without dmem_ack_i before the block enters ERROR (>=1)
// PORTS
//  clk_i            in   1      clock; all state changes on the rising edge
//  rst_i            in   1      asynchronous, active-low reset
//  start_i          in   1      level; leaves IDLE when 1
//  id_op_i          in   6      opcode of the instruction in ID
//  id_rs_i          in   5      rs field in ID
//  id_rt_i          in   5      rt field in ID
//  idex_memread_i   in   1      ID/EX holds a lw
//  idex_rt_i        in   5      destination rt of the ID/EX instruction
//  branch_eq_i      in   1      beq operands compare equal (resolved in ID)
//  exmem_access_i   in   1      EX/MEM holds a lw or sw
//  dmem_ack_i       in   1      data memory completes the access this cycle
//  dmem_req_o       out  1      data-memory request, held until ack
//  pc_write_o       out  1      PC register load enable
//  ifid_write_o     out  1      IF/ID load enable
//  ifid_flush_o     out  1      IF/ID loads a nop
//  idex_bubble_o    out  1      ID/EX control word forced to 9'b0
//  pipe_hold_o      out  1      ID/EX, EX/MEM and MEM/WB hold their contents
//  pc_src_o         out  2      00 pc+4, 01 branch target, 10 jump target
//  stall_cnt_o      out  CNT_W  cycles with pc_write_o=0 while in RUN or WAIT
//  flush_cnt_o      out  CNT_W  cycles with ifid_flush_o=1
//  err_o            out  1      memory timeout; sticky until reset
// BEHAVIOUR
//  Reset: state=IDLE; wait_cnt, stall_cnt_o, flush_cnt_o and err_o are 0.
//   In IDLE: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, dmem_req_o=0, pc_src_o=00.
//  States: IDLE->RUN when start_i=1. RUN->WAIT when hold=1. WAIT->RUN when dmem_ack_i=1.
//   WAIT->ERROR when wait_cnt reaches MEM_TIMEOUT. ERROR is exited only by reset.
//  All outputs except the counters and err_o are combinational from state and inputs (Mealy).
//  dmem_req_o = exmem_access_i in RUN; forced to 1 in WAIT.
//  hold = exmem_access_i & ~dmem_ack_i in RUN; 1 in WAIT until ack; 1 in ERROR.
//   Zero-wait ack (ack in the same cycle as the request) gives no stall.
//  When hold=1: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, ifid_flush_o=0, idex_bubble_o=0.
//   hold is 0 in the ack cycle; the pipeline advances in that cycle.
//  wait_cnt: cleared on entry to WAIT, incremented each WAIT cycle without ack.
//  Load-use stall, evaluated in RUN with hold=0: idex_memread_i & idex_rt_i!=0 &
//   (idex_rt_i==id_rs_i | (idex_rt_i==id_rt_i & id_op_i in {000000, 000100, 101011})).
//   Result: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, for exactly one cycle.
//   The stall is one cycle because the bubble clears idex_memread_i in the next cycle.
//  Flush, in RUN with hold=0 and no load-use stall:
//   - id_op_i=000010: pc_src_o=10, ifid_flush_o=1.
//   - id_op_i=000100 & branch_eq_i: pc_src_o=01, ifid_flush_o=1.
//   - Otherwise pc_src_o=00.
//  Priority: ERROR > hold > load-use stall > jump/branch flush > normal.
//   A beq stalled by load-use is not taken in the stall cycle; it is re-evaluated in the next cycle.
//  Counters saturate at all-ones and never wrap.
//  ERROR: all stages held, pc_write_o=0, dmem_req_o=0, err_o=1.
//  Reset asserted mid-WAIT drops dmem_req_o to 0 immediately (asynchronous).
// TESTING
//  1. Reset low, start_i=0 for 5 cycles -> pc_write_o=0, idex_bubble_o=1, counters 0. start_i=1 -> RUN next cycle, pc_write_o=1.
//  2. idex_memread_i=1, idex_rt_i=8, id_op_i=0, id_rs_i=8 -> one cycle with pc_write_o=0 and idex_bubble_o=1; stall_cnt_o=1.
//  3. id_op_i=000100, branch_eq_i=1, no hazard -> pc_src_o=01, ifid_flush_o=1 for 1 cycle; flush_cnt_o=1. id_op_i=000010 -> pc_src_o=10.
//  4. exmem_access_i=1, ack delayed 3 cycles -> dmem_req_o=1 for 4 cycles, pipe_hold_o=1 for 3 cycles; stall_cnt_o+=3. A branch during the hold is ignored.
//  5. exmem_access_i=1, ack never arrives, MEM_TIMEOUT=15 -> err_o=1 after the timeout, all holds stay 1; rst_i low clears err_o.
//  6. idex_rt_i=0 with idex_memread_i=1 and id_rs_i=0 -> no stall. CNT_W=4 with 20 stalls -> stall_cnt_o=15.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard and pipeline-control sequencer for the 5-stage MIPS core.
// It handles load-use bubbles, beq/j flushes, data-memory wait freezes, the start gate, a memory-timeout error, and stall/flush counters.
module pipeline_hazard_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       id_op_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_eq_i,
  input  logic             exmem_access_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic [1:0]       pc_src_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o,
  output logic [1:0]       state_o
);

  // Handshake: dmem_req_o is a valid that stays high until the cycle in which
  // dmem_ack_i is sampled high; that ack cycle completes the access, and the pipeline advances in it.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_clr, wait_inc;
  logic              hold;
  logic              rt_used;
  logic              load_use;
  logic              active;

  assign state_o = state;
  assign active  = (state == S_RUN) || (state == S_WAIT);

  // rt is a source operand only for R-type, beq and sw; for other opcodes it is the destination.
  assign rt_used  = (id_op_i == OP_RTYPE) || (id_op_i == OP_BEQ) || (id_op_i == OP_SW);
  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == id_rs_i) || ((idex_rt_i == id_rt_i) && rt_used));

  always_comb begin
    next_state    = state;
    wait_clr      = 1'b0;
    wait_inc      = 1'b0;
    hold          = 1'b0;
    dmem_req_o    = 1'b0;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    pc_src_o      = 2'b00;

    case (state)
      S_IDLE: begin
        idex_bubble_o = 1'b1;
        if (start_i) next_state = S_RUN;
      end
      S_RUN: begin
        dmem_req_o = exmem_access_i;
        hold       = exmem_access_i && !dmem_ack_i;
        if (hold) begin
          next_state = S_WAIT;
          wait_clr   = 1'b1;
        end
      end
      S_WAIT: begin
        dmem_req_o = 1'b1;
        hold       = !dmem_ack_i;
        if (dmem_ack_i) begin
          next_state = S_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_ERROR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      default: begin
        hold = 1'b1;
      end
    endcase

    // Priority below hold: load-use bubble, then jump/branch redirect, then straight-line fetch.
    if (hold) begin
      pipe_hold_o = 1'b1;
    end else if (active) begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      if (load_use) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (id_op_i == OP_J) begin
        pc_src_o     = 2'b10;
        ifid_flush_o = 1'b1;
      end else if ((id_op_i == OP_BEQ) && branch_eq_i) begin
        pc_src_o     = 2'b01;
        ifid_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= next_state;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (next_state == S_ERROR) err_o <= 1'b1;
      if (active && !pc_write_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (ifid_flush_o && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: a vector table for single-cycle RUN decisions
// plus hand sequences for start, memory wait, timeout, asynchronous reset and counter saturation.
module tb_pipeline_hazard_sequencer;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic       start_i, idex_memread_i, branch_eq_i, exmem_access_i, dmem_ack_i;
  logic [5:0] id_op_i;
  logic [4:0] id_rs_i, id_rt_i, idex_rt_i;

  logic        dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, err;
  logic [1:0]  pc_src, state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_dmem_req, s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_hold, s_err;
  logic [1:0]  s_pc_src, s_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  pipeline_hazard_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .id_op_i(id_op_i), .id_rs_i(id_rs_i),
    .id_rt_i(id_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .branch_eq_i(branch_eq_i), .exmem_access_i(exmem_access_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(dmem_req), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .pipe_hold_o(pipe_hold),
    .pc_src_o(pc_src), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_o(err),
    .state_o(state)
  );

  pipeline_hazard_sequencer #(.CNT_W(4), .MEM_TIMEOUT(15)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .id_op_i(id_op_i), .id_rs_i(id_rs_i),
    .id_rt_i(id_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .branch_eq_i(branch_eq_i), .exmem_access_i(exmem_access_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(s_dmem_req), .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
    .ifid_flush_o(s_ifid_flush), .idex_bubble_o(s_idex_bubble), .pipe_hold_o(s_pipe_hold),
    .pc_src_o(s_pc_src), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .err_o(s_err),
    .state_o(s_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [7:0] exp_q[$];

  // Packed control word: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, dmem_req, pc_src}
  localparam logic [7:0] W_NORMAL  = 8'b1100_0000;
  localparam logic [7:0] W_STALL   = 8'b0001_0000;
  localparam logic [7:0] W_BEQ     = 8'b1110_0001;
  localparam logic [7:0] W_JMP     = 8'b1110_0010;
  localparam logic [7:0] W_ZW      = 8'b1100_0100;
  localparam logic [7:0] W_ZW_JMP  = 8'b1110_0110;
  localparam logic [7:0] W_HOLDREQ = 8'b0000_1100;
  localparam logic [7:0] W_ERROR   = 8'b0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input string name, input logic [7:0] exp);
    logic [7:0] act, e;
    exp_q.push_back(exp);
    e   = exp_q.pop_front();
    act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, dmem_req, pc_src};
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, e, $time);
    end
    if (e[7] == 1'b0 && (state == ST_RUN || state == ST_WAIT)) exp_stall++;
    if (e[5]) exp_flush++;
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk_counters(input string name);
    chk({name, "_stall"},     32'(stall_cnt),   32'(exp_stall));
    chk({name, "_flush"},     32'(flush_cnt),   32'(exp_flush));
    chk({name, "_sat_stall"}, 32'(s_stall_cnt), 32'(sat15(exp_stall)));
    chk({name, "_sat_flush"}, 32'(s_flush_cnt), 32'(sat15(exp_flush)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic mr, input logic [4:0] irt, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic beq,
                        input logic acc, input logic ack);
    idex_memread_i = mr;
    idex_rt_i      = irt;
    id_op_i        = op;
    id_rs_i        = rs;
    id_rt_i        = rt;
    branch_eq_i    = beq;
    exmem_access_i = acc;
    dmem_ack_i     = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mr;
    logic [4:0] irt;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       beq;
    logic       acc;
    logic       ack;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, W_NORMAL};
    vecs[1]  = '{1'b1, 5'd8, 6'h00, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, W_STALL};
    vecs[2]  = '{1'b1, 5'd9, 6'h00, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, W_STALL};
    vecs[3]  = '{1'b1, 5'd9, 6'h08, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, W_NORMAL};
    vecs[4]  = '{1'b1, 5'd9, 6'h2B, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, W_STALL};
    vecs[5]  = '{1'b1, 5'd9, 6'h04, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, W_STALL};
    vecs[6]  = '{1'b0, 5'd9, 6'h04, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, W_BEQ};
    vecs[7]  = '{1'b1, 5'd0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, W_NORMAL};
    vecs[8]  = '{1'b0, 5'd0, 6'h02, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, W_JMP};
    vecs[9]  = '{1'b1, 5'd5, 6'h02, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, W_STALL};
    vecs[10] = '{1'b0, 5'd0, 6'h04, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, W_NORMAL};
    vecs[11] = '{1'b0, 5'd0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, W_ZW};
    vecs[12] = '{1'b0, 5'd0, 6'h02, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, W_ZW_JMP};
    vecs[13] = '{1'b0, 5'd8, 6'h00, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, W_NORMAL};
    vecs[14] = '{1'b1, 5'd8, 6'h23, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, W_NORMAL};

    // Reset held, then IDLE with start low.
    rst_i   = 1'b0;
    start_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    chk("reset_state", 32'(state), 32'(ST_IDLE));
    chk("reset_err", 32'(err), 0);
    chk_counters("reset");
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      chk("idle_state", 32'(state), 32'(ST_IDLE));
      chk("idle_pc_write", 32'(pc_write), 0);
      chk("idle_ifid_write", 32'(ifid_write), 0);
      chk("idle_bubble", 32'(idex_bubble), 1);
      chk("idle_req", 32'(dmem_req), 0);
      chk("idle_pc_src", 32'(pc_src), 0);
    end
    chk_counters("idle");
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    chk("start_state", 32'(state), 32'(ST_RUN));
    #1;
    chk("start_pc_write", 32'(pc_write), 1);

    // Single-cycle RUN decisions from the table.
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].mr, vecs[i].irt, vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].beq, vecs[i].acc, vecs[i].ack);
      #1;
      expect_word($sformatf("vec%0d", i), vecs[i].exp);
      next_cycle();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(ST_RUN));
      chk_counters($sformatf("vec%0d", i));
    end

    // Memory access acknowledged after three wait cycles; branch during hold ignored.
    set_in(0, 0, 6'h04, 0, 0, 1, 1, 0);
    #1;
    expect_word("memwait_req_cycle", W_HOLDREQ);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      chk("memwait_state", 32'(state), 32'(ST_WAIT));
      #1;
      expect_word($sformatf("memwait_hold%0d", i), W_HOLDREQ);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    expect_word("memwait_ack", W_ZW);
    next_cycle();
    chk("memwait_back_run", 32'(state), 32'(ST_RUN));
    chk_counters("memwait");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    expect_word("memwait_after", W_NORMAL);
    next_cycle();

    // Ack never arrives: fifteen wait cycles, then ERROR.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    expect_word("timeout_req", W_HOLDREQ);
    next_cycle();
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("timeout_wait%0d_state", k), 32'(state), 32'(ST_WAIT));
      chk($sformatf("timeout_wait%0d_err", k), 32'(err), 0);
      #1;
      expect_word($sformatf("timeout_wait%0d", k), W_HOLDREQ);
      next_cycle();
    end
    chk("timeout_state", 32'(state), 32'(ST_ERROR));
    chk("timeout_err", 32'(err), 1);
    chk("timeout_sat_err", 32'(s_err), 1);
    dmem_ack_i = 1'b1;
    #1;
    expect_word("error_word", W_ERROR);
    next_cycle();
    chk("error_sticky_state", 32'(state), 32'(ST_ERROR));
    chk("error_sticky_err", 32'(err), 1);
    chk_counters("error");
    rst_i = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    chk("err_cleared", 32'(err), 0);
    chk("err_reset_state", 32'(state), 32'(ST_IDLE));
    chk_counters("err_reset");
    next_cycle();
    rst_i = 1'b1;

    // Asynchronous reset during WAIT drops the request without a clock edge.
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    next_cycle();
    chk("async_wait_state", 32'(state), 32'(ST_WAIT));
    chk("async_req_before", 32'(dmem_req), 1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("async_req_after", 32'(dmem_req), 0);
    chk("async_state_after", 32'(state), 32'(ST_IDLE));
    exp_stall = 0;
    next_cycle();
    rst_i = 1'b1;
    chk_counters("async");

    // Twenty load-use stalls: the 4-bit counter saturates at 15.
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_in(1, 5'd8, 6'h00, 5'd8, 5'd0, 0, 0, 0);
      #1;
      expect_word($sformatf("sat_stall%0d", k), W_STALL);
      next_cycle();
    end
    chk("sat_stall_full", 32'(stall_cnt), 20);
    chk("sat_stall_4bit", 32'(s_stall_cnt), 15);
    chk_counters("sat");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    expect_word("sat_resume", W_NORMAL);
    next_cycle();
    chk("sat_hold_4bit", 32'(s_stall_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
